rv32_mem_arbiter: RTL

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

---
 rtl/rv32_mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mem_arbiter
// Description : Arbitrates instruction-fetch (IF) and data (DM) requests onto
//               one single-port memory with one transaction in flight. DM is
//               preferred, but IF is forced through after STARVE_LIMIT losses.
//               A fetch redirect drops the pending IF response.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_wait,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);
   localparam logic       OWNER_IF = 1'b0;
   localparam logic       OWNER_DM = 1'b1;

   state_t      state;
   state_t      state_next;
   logic        owner;
   logic        cmd_we;
   logic [3:0]  cmd_be;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [2:0]  starve_cnt;
   logic        discard;
   logic        if_win;
   logic        dm_win;
   logic        if_kill;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and winner selection; winners only exist in IDLE
   always_comb begin
      state_next = state;
      if_win     = 1'b0;
      dm_win     = 1'b0;
      case (state)
         IDLE: begin
            if (if_req && (starve_cnt == LIMIT)) begin
               if_win = 1'b1;
            end else if (dm_req) begin
               dm_win = 1'b1;
            end else if (if_req) begin
               if_win = 1'b1;
            end
            if (if_win || dm_win) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (mem_rvalid) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grants are combinational pulses in the arbitration cycle, held off in reset
   assign if_gnt  = if_win & ~reset;
   assign dm_gnt  = dm_win & ~reset;
   assign if_wait = if_req & ~if_gnt;

   // A flush arriving in the same cycle as the response still kills it
   assign if_kill = discard | if_flush;

   // Memory command comes straight from the latched command registers
   assign mem_req   = (state == REQ);
   assign mem_we    = cmd_we;
   assign mem_be    = cmd_be;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

   // Starvation counter, command latch, flush tracking and response delivery
   always_ff @(posedge clk) begin
      if (reset) begin
         owner      <= OWNER_IF;
         cmd_we     <= 1'b0;
         cmd_be     <= 4'h0;
         cmd_addr   <= 32'h0;
         cmd_wdata  <= 32'h0;
         starve_cnt <= 3'd0;
         discard    <= 1'b0;
         if_rvalid  <= 1'b0;
         dm_rvalid  <= 1'b0;
         if_rdata   <= 32'h0;
         dm_rdata   <= 32'h0;
      end else begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               discard <= 1'b0;
               if (if_req && dm_win) begin
                  if (starve_cnt != LIMIT) begin
                     starve_cnt <= starve_cnt + 3'd1;
                  end
               end else begin
                  starve_cnt <= 3'd0;
               end
               if (if_win) begin
                  owner     <= OWNER_IF;
                  cmd_we    <= 1'b0;
                  cmd_be    <= 4'hF;
                  cmd_addr  <= if_addr;
                  cmd_wdata <= 32'h0;
               end else if (dm_win) begin
                  owner     <= OWNER_DM;
                  cmd_we    <= dm_we;
                  cmd_be    <= dm_be;
                  cmd_addr  <= dm_addr;
                  cmd_wdata <= dm_wdata;
               end
            end
            REQ: begin
               if ((owner == OWNER_IF) && if_flush) begin
                  discard <= 1'b1;
               end
            end
            RESP: begin
               if ((owner == OWNER_IF) && if_flush) begin
                  discard <= 1'b1;
               end
               if (mem_rvalid) begin
                  discard <= 1'b0;
                  if (owner == OWNER_DM) begin
                     dm_rdata  <= mem_rdata;
                     dm_rvalid <= 1'b1;
                  end else if (!if_kill) begin
                     if_rdata  <= mem_rdata;
                     if_rvalid <= 1'b1;
                  end
               end
            end
            default: begin
               discard <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
